// File: rtl/branch_predictor.sv
// Fetch-stage branch classifier with 2-bit counter direction predictor and tagged BTB.
// Latency: lookup is combinational (0 cycles); training and statistics commit on the next clk edge.
// Backpressure: none; every fetch lookup and every ex_update strobe is consumed in its own cycle.
module branch_predictor #(
  parameter int         WIDTH_DATA_LENGTH = 32,
  parameter int         INDEX_BITS        = 6,
  parameter int         TAG_BITS          = 8,
  parameter logic [1:0] CNT_INIT          = 2'b01,
  parameter int         STAT_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH_DATA_LENGTH-1:0] if_pc,
  input  logic [WIDTH_DATA_LENGTH-1:0] if_inst,
  output logic                         br_detected,
  output logic [1:0]                   br_type,
  output logic                         pred_taken,
  output logic [WIDTH_DATA_LENGTH-1:0] pred_target,
  input  logic                         ex_update,
  input  logic [WIDTH_DATA_LENGTH-1:0] ex_pc,
  input  logic [1:0]                   ex_type,
  input  logic                         ex_taken,
  input  logic [WIDTH_DATA_LENGTH-1:0] ex_target,
  input  logic                         ex_mispredict,
  output logic [STAT_WIDTH-1:0]        stat_branches,
  output logic [STAT_WIDTH-1:0]        stat_mispredicts
);

  localparam int W       = WIDTH_DATA_LENGTH;
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_COND = 2'b01;
  localparam logic [1:0] T_JAL  = 2'b10;
  localparam logic [1:0] T_JALR = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [W-1:0]        target;
    logic [1:0]          cnt;
  } entry_t;

  entry_t table_q [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   ex_tag;
  entry_t                if_entry;
  logic                  if_hit;
  logic [W-1:0]          pc_plus4;
  logic [W-1:0]          jal_imm;
  logic [1:0]            ex_cnt;
  logic [1:0]            ex_cnt_next;

  assign if_idx   = if_pc[INDEX_BITS+1:2];
  assign if_tag   = if_pc[TAG_HI:TAG_LO];
  assign ex_idx   = ex_pc[INDEX_BITS+1:2];
  assign ex_tag   = ex_pc[TAG_HI:TAG_LO];
  assign if_entry = table_q[if_idx];
  assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);
  assign pc_plus4 = if_pc + W'(4);
  assign jal_imm  = {{(W-21){if_inst[31]}}, if_inst[31], if_inst[19:12],
                     if_inst[20], if_inst[30:21], 1'b0};
  assign ex_cnt   = table_q[ex_idx].cnt;

  // Low PC bits, PC bits above the tag and non-opcode instruction fields are not used for lookup.
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], if_pc[W-1:TAG_HI+1], ex_pc[1:0], ex_pc[W-1:TAG_HI+1],
                         if_inst[11:7], if_inst[1:0]};

  // Classify the fetched opcode and form the direction/target prediction.
  always_comb begin
    br_type     = T_NONE;
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    unique case (if_inst[6:2])
      OP_BRANCH: begin
        br_type = T_COND;
        if (if_hit && if_entry.cnt[1]) begin
          pred_taken  = 1'b1;
          pred_target = if_entry.target;
        end
      end
      OP_JAL: begin
        br_type     = T_JAL;
        pred_taken  = 1'b1;
        pred_target = if_pc + jal_imm;
      end
      OP_JALR: begin
        br_type = T_JALR;
        if (if_hit) begin
          pred_taken  = 1'b1;
          pred_target = if_entry.target;
        end
      end
      default: ;
    endcase
    br_detected = (br_type != T_NONE);
  end

  // Saturating counter step for the entry selected by the resolved PC.
  always_comb begin
    ex_cnt_next = ex_cnt;
    if (ex_taken) begin
      if (ex_cnt != 2'b11) ex_cnt_next = ex_cnt + 2'b01;
    end else begin
      if (ex_cnt != 2'b00) ex_cnt_next = ex_cnt - 2'b01;
    end
  end

  // Train the table; a write on a tag mismatch replaces the entry but keeps its counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid  <= 1'b0;
        table_q[i].tag    <= '0;
        table_q[i].target <= '0;
        table_q[i].cnt    <= CNT_INIT;
      end
    end else if (ex_update) begin
      case (ex_type)
        T_COND: begin
          table_q[ex_idx].cnt <= ex_cnt_next;
          if (ex_taken) begin
            table_q[ex_idx].valid  <= 1'b1;
            table_q[ex_idx].tag    <= ex_tag;
            table_q[ex_idx].target <= ex_target;
          end
        end
        T_JALR: begin
          table_q[ex_idx].valid  <= 1'b1;
          table_q[ex_idx].tag    <= ex_tag;
          table_q[ex_idx].target <= ex_target;
        end
        default: ;
      endcase
    end
  end

  // Saturating resolved-branch and misprediction counters; non-branch updates are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (ex_update && (ex_type != T_NONE)) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (ex_mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios then random fetch/train traffic vs a table model.
// Two instances share stimulus: default statistics width and a 4-bit width for saturation.
// Outputs are sampled between clock edges; inputs change 1 time unit after the rising edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_inst, ex_pc, ex_target;
  logic        ex_update, ex_taken, ex_mispredict;
  logic [1:0]  ex_type;

  logic        br_detected, pred_taken;
  logic [1:0]  br_type;
  logic [31:0] pred_target, stat_branches, stat_mispredicts;

  logic        br_detected4, pred_taken4;
  logic [1:0]  br_type4;
  logic [31:0] pred_target4;
  logic [3:0]  stat_branches4, stat_mispredicts4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst),
    .br_detected(br_detected), .br_type(br_type), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_update(ex_update), .ex_pc(ex_pc),
    .ex_type(ex_type), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_mispredict(ex_mispredict), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor #(.STAT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst),
    .br_detected(br_detected4), .br_type(br_type4), .pred_taken(pred_taken4),
    .pred_target(pred_target4), .ex_update(ex_update), .ex_pc(ex_pc),
    .ex_type(ex_type), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_mispredict(ex_mispredict), .stat_branches(stat_branches4),
    .stat_mispredicts(stat_mispredicts4)
  );

  // Reference model: 64 entries, index = word address mod 64, tag = next 8 bits.
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [64];
  int          n_br, n_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3F);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return (pc >> 8) & 32'hFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_cnt[i]   = 1;
    end
    n_br  = 0;
    n_mis = 0;
  endtask

  task automatic model_edge();
    int i;
    if (rst) begin
      model_reset();
    end else if (ex_update) begin
      i = idx_of(ex_pc);
      if (ex_type == 2'd1) begin
        if (ex_taken) begin
          m_cnt[i]   = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_valid[i] = 1'b1;
          m_tag[i]   = tag_of(ex_pc);
          m_tgt[i]   = ex_target;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (ex_type == 2'd3) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(ex_pc);
        m_tgt[i]   = ex_target;
      end
      if (ex_type != 2'd0) begin
        n_br++;
        if (ex_mispredict) n_mis++;
      end
    end
  endtask

  task automatic model_predict(output logic [1:0] typ, output logic tk, output logic [31:0] tgt);
    int          op;
    int          i;
    bit          hit;
    logic [31:0] imm;
    op  = int'((if_inst >> 2) & 32'h1F);
    i   = idx_of(if_pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(if_pc));
    typ = 2'd0;
    tk  = 1'b0;
    tgt = if_pc + 4;
    if (op == 24) begin
      typ = 2'd1;
      if (hit && m_cnt[i] >= 2) begin
        tk  = 1'b1;
        tgt = m_tgt[i];
      end
    end else if (op == 27) begin
      typ = 2'd2;
      tk  = 1'b1;
      imm = (((if_inst >> 12) & 32'hFF) << 12) | (((if_inst >> 20) & 32'h1) << 11) |
            (((if_inst >> 21) & 32'h3FF) << 1);
      if (if_inst[31]) imm = imm | 32'hFFF0_0000;
      tgt = if_pc + imm;
    end else if (op == 25) begin
      typ = 2'd3;
      if (hit) begin
        tk  = 1'b1;
        tgt = m_tgt[i];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [1:0]  typ;
    logic        tk;
    logic [31:0] tgt;
    model_predict(typ, tk, tgt);
    chk("br_type", {30'd0, br_type}, {30'd0, typ});
    chk("br_detected", {31'd0, br_detected}, {31'd0, typ != 2'd0});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, tk});
    chk("pred_target", pred_target, tgt);
    chk("pred_target_w4", pred_target4, tgt);
    chk("stat_branches", stat_branches, n_br);
    chk("stat_mispredicts", stat_mispredicts, n_mis);
    chk("stat_branches_w4", {28'd0, stat_branches4}, (n_br > 15) ? 15 : n_br);
    chk("stat_mispredicts_w4", {28'd0, stat_mispredicts4}, (n_mis > 15) ? 15 : n_mis);
  endtask

  // Check current outputs against the model, then clock one edge and advance the model.
  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1; if_pc = 0; if_inst = 0; ex_update = 0; ex_pc = 0;
    ex_type = 0; ex_taken = 0; ex_target = 0; ex_mispredict = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Untrained conditional branch falls through; statistics start at zero.
    if_pc = 32'h100; if_inst = 32'h0000_0063;
    #1;
    chk("reset_cond_type", {30'd0, br_type}, 32'd1);
    chk("reset_cond_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset_cond_target", pred_target, 32'h104);
    chk("reset_stat_br", stat_branches, 32'd0);
    chk("reset_stat_mis", stat_mispredicts, 32'd0);
    step();

    // JAL predicted from the immediate alone.
    if_inst = 32'h0080_006F;
    #1;
    chk("jal_type", {30'd0, br_type}, 32'd2);
    chk("jal_taken", {31'd0, pred_taken}, 32'd1);
    chk("jal_target", pred_target, 32'h108);
    step();

    // Two taken trainings at 0x200 make it predicted taken.
    ex_update = 1; ex_pc = 32'h200; ex_type = 2'd1; ex_taken = 1;
    ex_target = 32'h180; ex_mispredict = 1;
    step();
    step();
    ex_update = 0; if_pc = 32'h200; if_inst = 32'h0000_0063;
    #1;
    chk("trained_taken", {31'd0, pred_taken}, 32'd1);
    chk("trained_target", pred_target, 32'h180);
    step();

    // Three not-taken updates saturate the counter at 00.
    ex_update = 1; ex_taken = 0;
    repeat (3) step();
    ex_update = 0;
    #1;
    chk("untrained_taken", {31'd0, pred_taken}, 32'd0);
    chk("untrained_target", pred_target, 32'h204);
    step();

    // Same-cycle update and lookup: lookup sees pre-update state.
    ex_update = 1; ex_taken = 1;
    step();
    #1;
    chk("same_cycle_old", {31'd0, pred_taken}, 32'd0);
    step();
    ex_update = 0;
    #1;
    chk("same_cycle_new", {31'd0, pred_taken}, 32'd1);
    chk("same_cycle_new_tgt", pred_target, 32'h180);
    step();

    // JALR trained at 0x40; an aliasing PC with a different tag misses.
    ex_update = 1; ex_pc = 32'h40; ex_type = 2'd3; ex_taken = 1; ex_target = 32'h300;
    step();
    ex_update = 0; if_pc = 32'h40; if_inst = 32'h0000_0067;
    #1;
    chk("jalr_hit_taken", {31'd0, pred_taken}, 32'd1);
    chk("jalr_hit_target", pred_target, 32'h300);
    step();
    if_pc = 32'h140;
    #1;
    chk("jalr_alias_taken", {31'd0, pred_taken}, 32'd0);
    chk("jalr_alias_target", pred_target, 32'h144);
    step();

    // Statistics saturation on the 4-bit instance; type-00 updates are not counted.
    rst = 1;
    step();
    rst = 0;
    ex_update = 1; ex_pc = 32'h500; ex_type = 2'd1; ex_taken = 0; ex_mispredict = 1;
    repeat (20) step();
    ex_type = 2'd0;
    repeat (3) step();
    ex_update = 0;
    #1;
    chk("sat_br_w4", {28'd0, stat_branches4}, 32'hF);
    chk("sat_mis_w4", {28'd0, stat_mispredicts4}, 32'hF);
    chk("count_br", stat_branches, 32'd20);
    chk("count_mis", stat_mispredicts, 32'd20);
    step();
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("stat_clear_br_w4", {28'd0, stat_branches4}, 32'd0);
    chk("stat_clear_mis_w4", {28'd0, stat_mispredicts4}, 32'd0);
    chk("stat_clear_br", stat_branches, 32'd0);
    step();

    // Random fetch and training traffic over a small aliasing PC set.
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] op5;
      case ($urandom_range(0, 4))
        0: op5 = 5'b11000;
        1: op5 = 5'b11011;
        2: op5 = 5'b11001;
        3: op5 = 5'b11000;
        default: op5 = 5'($urandom);
      endcase
      if_pc         = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8);
      if_inst       = ($urandom & 32'hFFFF_FF80) | {25'd0, op5, 2'($urandom)};
      rst           = ($urandom_range(0, 99) == 0);
      ex_update     = $urandom_range(0, 1) == 1;
      ex_pc         = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8);
      ex_type       = 2'($urandom);
      ex_taken      = $urandom_range(0, 2) != 0;
      ex_target     = $urandom & 32'hFFFF_FFFC;
      ex_mispredict = $urandom_range(0, 1) == 1;
      step();
    end
    rst = 0;
    ex_update = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch detector and predictor for the RV32I pipeline. It decodes the fetched instruction's opcode field to classify control-flow instructions. It predicts direction with a table of 2-bit saturating counters and predicts target with a direct-mapped, tagged branch target buffer (BTB). The EX stage trains it with resolved outcomes, and it keeps saturating statistics counters for resolved branches and mispredictions.

## Interface
- WIDTH_DATA_LENGTH, 32: instruction and PC width.
- INDEX_BITS, 6: table index width; table has 2^INDEX_BITS entries.
- TAG_BITS, 8: BTB tag width.
- CNT_INIT, 2'b01: counter reset value (weakly not-taken).
- STAT_WIDTH, 32: statistics counter width.

- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  WIDTH_DATA_LENGTH  PC of the fetched instruction.
- if_inst  in  WIDTH_DATA_LENGTH  fetched instruction.
- br_detected  out  1  fetched instruction is BRANCH, JAL or JALR.
- br_type  out  2  00 none, 01 conditional (Inst[6:2]=11000), 10 JAL (11011), 11 JALR (11001).
- pred_taken  out  1  predicted taken.
- pred_target  out  WIDTH_DATA_LENGTH  predicted next PC.
- ex_update  in  1  resolved-branch update strobe from EX.
- ex_pc  in  WIDTH_DATA_LENGTH  PC of the resolved instruction.
- ex_type  in  2  br_type of the resolved instruction, same encoding.
- ex_taken  in  1  resolved direction.
- ex_target  in  WIDTH_DATA_LENGTH  resolved target.
- ex_mispredict  in  1  EX found the prediction wrong (direction or target).
- stat_branches  out  STAT_WIDTH  count of resolved branches.
- stat_mispredicts  out  STAT_WIDTH  count of mispredictions.

## Operation
- Classification uses only Inst[6:2]. Inst[1:0] is ignored. Every other opcode gives br_type=00 and br_detected=0.
- Index: pc[INDEX_BITS+1:2]. Tag: pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- Per entry state: valid bit, TAG_BITS tag, WIDTH_DATA_LENGTH target, 2-bit counter.
- BTB hit condition: valid[idx] is set and the stored tag equals the tag of if_pc.
- Prediction by br_type:
  - none: pred_taken=0, pred_target=if_pc+4.
  - JAL: pred_taken=1, pred_target=if_pc + sign-extended J-immediate {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}. The BTB is not consulted.
  - JALR: pred_taken=hit. pred_target is the BTB target on a hit, otherwise if_pc+4.
  - conditional: pred_taken=hit AND counter[idx][1]. pred_target is the BTB target when pred_taken=1, otherwise if_pc+4.
- Update happens when ex_update=1 and rst=0. The entry is selected by ex_pc.
  - ex_type=01: counter increments if ex_taken=1, saturating at 11. It decrements if ex_taken=0, saturating at 00. When ex_taken=1, also write valid=1, the tag and ex_target.
  - ex_type=11: write valid=1, the tag and ex_target regardless of ex_taken. Counter is unchanged.
  - ex_type=10: no table change.
  - ex_type=00: no table change and no statistics change.
- A tag mismatch on write replaces the entry: new tag, new target, valid=1. The counter is not reset on replacement.
- Statistics, for ex_update=1 with ex_type≠00:
  - stat_branches increments by 1.
  - stat_mispredicts increments by 1 when ex_mispredict=1.
  - Both counters saturate at all-ones and never wrap.
- Reset (rst=1 at a rising edge):
  - all valid bits cleared;
  - all counters set to CNT_INIT;
  - tags and targets cleared to 0;
  - stat_branches=0, stat_mispredicts=0.
  - ex_update is ignored in the same cycle.

## Timing
- Lookup is zero latency. br_detected, br_type, pred_taken and pred_target are combinational from if_pc, if_inst and the current table state.
- Updates take effect at the rising edge that samples ex_update. They are visible to lookups from the next cycle.
- A lookup and an update to the same index in the same cycle: the lookup returns pre-update state. There is no bypass.
- Statistics outputs are registered and change one edge after the qualifying ex_update.
- After reset, until trained, every BTB lookup misses. pred_taken is 0 for conditional and JALR, and 1 for JAL.
- Reset asserted mid-training discards all learned state at that edge.

## Test plan
- Reset, then fetch a conditional branch (if_inst=0x00000063) at pc=0x100 → br_type=01, pred_taken=0, pred_target=0x104. Both statistics read 0.
- At pc=0x100, JAL with inst=0x0080006F (imm=+8) → br_type=10, pred_taken=1, pred_target=0x108, with no prior training.
- Train a conditional branch at pc=0x200 with ex_taken=1, ex_target=0x180, twice. On the next cycle fetch pc=0x200 → pred_taken=1, pred_target=0x180. Apply three not-taken updates → counter reaches 00 and pred_taken=0.
- Train a JALR at pc=0x40 to target 0x300, then fetch pc=0x40 and pc=0x40+(4<<INDEX_BITS) (same index, different tag) → hit with target 0x300, then miss with pred_taken=0.
- Update and lookup pc=0x200 in the same cycle → the lookup shows old state, and the next cycle shows the new state.
- With STAT_WIDTH=4, apply 20 updates with ex_type=01 and ex_mispredict=1, plus 3 updates with ex_type=00 → both counters read 4'hF. A following reset clears both to 0.
